// File: rtl/fdiv_issue_arb_pkg.sv
// Purpose: shared constants, FSM state type and the sequence-number kill compare for the divide issue arbiter.
// Latency: n/a (types and a pure combinational helper function).
// Backpressure: n/a.
package fdiv_issue_arb_pkg;

    localparam int DEF_TAG_W = 7;
    localparam int DEF_SQN_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        DONE
    } fsm_state_e;

    // An op is younger than the mispredicted branch (and must die) when
    // op_sqn - br_sqn, taken modulo 2**w, is strictly positive as a signed
    // w-bit value. The operands are zero-extended to 32 bits by the caller.
    function automatic logic sqn_killed(
        input logic        br_vld,
        input logic [31:0] op_sqn,
        input logic [31:0] br_sqn,
        input int          w
    );
        logic [31:0] mask;
        logic [31:0] diff;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        diff = (op_sqn - br_sqn) & mask;
        return br_vld && (diff != 32'd0) && (((diff >> (w - 1)) & 32'd1) == 32'd0);
    endfunction

endpackage

// File: rtl/fdiv_issue_arb_if.sv
// Purpose: bundle of issue-port, branch-flush, divider and writeback signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on issue ports and divider input, valid/ack on writeback.
// Modports: slave = arbiter view, master = environment (issue ports, divider, writeback) view.
interface fdiv_issue_arb_if
    import fdiv_issue_arb_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int TAG_W = DEF_TAG_W,
    parameter int SQN_W = DEF_SQN_W
);
    logic [NPORT-1:0]             req_valid;
    logic [NPORT-1:0]             req_sqrt;
    logic [NPORT-1:0][TAG_W-1:0]  req_tag;
    logic [NPORT-1:0][SQN_W-1:0]  req_sqn;
    logic [NPORT-1:0][31:0]       req_a;
    logic [NPORT-1:0][31:0]       req_b;
    logic [NPORT-1:0]             req_ready;

    logic                         br_valid;
    logic [SQN_W-1:0]             br_sqn;

    logic                         div_in_valid;
    logic                         div_in_ready;
    logic                         div_sqrt;
    logic [31:0]                  div_a;
    logic [31:0]                  div_b;
    logic                         div_out_valid;
    logic [31:0]                  div_out_result;

    logic                         wb_valid;
    logic [TAG_W-1:0]             wb_tag;
    logic [SQN_W-1:0]             wb_sqn;
    logic [31:0]                  wb_result;
    logic                         wb_ack;

    modport slave (
        input  req_valid, req_sqrt, req_tag, req_sqn, req_a, req_b,
        output req_ready,
        input  br_valid, br_sqn,
        output div_in_valid, div_sqrt, div_a, div_b,
        input  div_in_ready, div_out_valid, div_out_result,
        output wb_valid, wb_tag, wb_sqn, wb_result,
        input  wb_ack
    );

    modport master (
        output req_valid, req_sqrt, req_tag, req_sqn, req_a, req_b,
        input  req_ready,
        output br_valid, br_sqn,
        input  div_in_valid, div_sqrt, div_a, div_b,
        output div_in_ready, div_out_valid, div_out_result,
        input  wb_valid, wb_tag, wb_sqn, wb_result,
        output wb_ack
    );

endinterface

// File: rtl/fdiv_issue_arb_rr_arbiter.sv
// Purpose: round-robin one-hot arbiter; priority starts at the port after the last grant.
// Latency: grant is combinational from req; pointer updates on the clock edge where adv is high.
// Backpressure: none; caller gates req and asserts adv only when the grant is consumed.
// Ports: clk, rst (sync, active-high), req[NPORT], adv, grant[NPORT] one-hot.
module rr_arbiter #(
    parameter int NPORT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    input  logic             adv,
    output logic [NPORT-1:0] grant
);
    localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] gnt_idx;

    always_comb begin
        int  idx;
        logic found;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NPORT; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NPORT) idx = idx - NPORT;
            if (!found && req[idx]) begin
                found        = 1'b1;
                grant[idx]   = 1'b1;
                gnt_idx      = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (adv) begin
            ptr_q <= (int'(gnt_idx) == NPORT - 1) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fdiv_issue_arb.sv
// Purpose: shares one FP divide/sqrt unit among NPORT issue ports, with branch-flush kill and writeback.
// Latency: grant at N, divider request at N+1, writeback the cycle after div_out_valid.
// Backpressure: one op in flight; req_ready held low until the op retires, is killed or drains.
// Ports: clk, rst (sync, active-high), bus (fdiv_issue_arb_if.slave).
module fdiv_issue_arb
    import fdiv_issue_arb_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int TAG_W = DEF_TAG_W,
    parameter int SQN_W = DEF_SQN_W
) (
    input  logic           clk,
    input  logic           rst,
    fdiv_issue_arb_if.slave bus
);
    fsm_state_e       st;

    logic             op_sqrt;
    logic [TAG_W-1:0] op_tag;
    logic [SQN_W-1:0] op_sqn;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [31:0]      op_res;

    logic [NPORT-1:0] port_kill;
    logic [NPORT-1:0] arb_req;
    logic [NPORT-1:0] arb_gnt;
    logic             accept;
    logic             op_kill;

    logic             sel_sqrt;
    logic [TAG_W-1:0] sel_tag;
    logic [SQN_W-1:0] sel_sqn;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;

    always_comb begin
        port_kill = '0;
        for (int i = 0; i < NPORT; i++) begin
            port_kill[i] = sqn_killed(bus.br_valid, 32'(bus.req_sqn[i]), 32'(bus.br_sqn), SQN_W);
        end
    end

    assign op_kill = sqn_killed(bus.br_valid, 32'(op_sqn), 32'(bus.br_sqn), SQN_W);

    // Killed requests never reach the arbiter, so they can neither be granted
    // nor advance the round-robin pointer.
    assign arb_req = (st == IDLE && !rst) ? (bus.req_valid & ~port_kill) : '0;
    assign accept  = |arb_gnt;
    assign bus.req_ready = arb_gnt;

    rr_arbiter #(.NPORT(NPORT)) u_rr_arbiter (
        .clk   (clk),
        .rst   (rst),
        .req   (arb_req),
        .adv   (accept),
        .grant (arb_gnt)
    );

    always_comb begin
        sel_sqrt = 1'b0;
        sel_tag  = '0;
        sel_sqn  = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (arb_gnt[i]) begin
                sel_sqrt = bus.req_sqrt[i];
                sel_tag  = bus.req_tag[i];
                sel_sqn  = bus.req_sqn[i];
                sel_a    = bus.req_a[i];
                sel_b    = bus.req_b[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            case (st)
                IDLE:  if (accept) st <= ISSUE;
                ISSUE: begin
                    if (op_kill)               st <= IDLE;
                    else if (bus.div_in_ready) st <= WAIT;
                end
                WAIT: begin
                    // A kill coinciding with the result means the divider is
                    // already empty; draining would wait for a result that
                    // never comes.
                    if (op_kill)                st <= bus.div_out_valid ? IDLE : DRAIN;
                    else if (bus.div_out_valid) st <= DONE;
                end
                DRAIN: if (bus.div_out_valid) st <= IDLE;
                DONE:  if (op_kill || bus.wb_ack) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (st == IDLE && accept) begin
            op_sqrt <= sel_sqrt;
            op_tag  <= sel_tag;
            op_sqn  <= sel_sqn;
            op_a    <= sel_a;
            op_b    <= sel_b;
        end
        if (st == WAIT && bus.div_out_valid) begin
            op_res <= bus.div_out_result;
        end
    end

    // Same-cycle kill suppresses the handshakes outright, so a flushed op
    // never reaches the divider from ISSUE and never writes back from DONE.
    assign bus.div_in_valid = (st == ISSUE) && !op_kill && !rst;
    assign bus.div_sqrt     = op_sqrt;
    assign bus.div_a        = op_a;
    assign bus.div_b        = op_b;

    assign bus.wb_valid     = (st == DONE) && !op_kill && !rst;
    assign bus.wb_tag       = op_tag;
    assign bus.wb_sqn       = op_sqn;
    assign bus.wb_result    = op_res;

endmodule

// File: tb/tb_fdiv_issue_arb.sv
module tb_fdiv_issue_arb;
    import fdiv_issue_arb_pkg::*;

    localparam int NPORT = 2;
    localparam int TAG_W = 7;
    localparam int SQN_W = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fdiv_issue_arb_if #(.NPORT(NPORT), .TAG_W(TAG_W), .SQN_W(SQN_W)) bus ();

    fdiv_issue_arb #(.NPORT(NPORT), .TAG_W(TAG_W), .SQN_W(SQN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] vld;
        logic [6:0] sqn0;
        logic [6:0] sqn1;
        logic       brv;
        logic [6:0] brs;
        logic [1:0] exp_rdy;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_valid      = '0;
        bus.req_sqrt       = '0;
        bus.req_tag        = '0;
        bus.req_sqn        = '0;
        bus.req_a          = '0;
        bus.req_b          = '0;
        bus.br_valid       = 1'b0;
        bus.br_sqn         = '0;
        bus.div_in_ready   = 1'b1;
        bus.div_out_valid  = 1'b0;
        bus.div_out_result = '0;
        bus.wb_ack         = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer one op on port p from IDLE, check grant and the divider request,
    // and leave the FSM in WAIT (div_in_ready is 1).
    task automatic issue(input int p, input logic [6:0] sqn, input logic [6:0] tag,
                         input logic [31:0] a, input logic [31:0] b, input logic sq);
        bus.req_valid    = '0;
        bus.req_valid[p] = 1'b1;
        bus.req_sqn[p]   = sqn;
        bus.req_tag[p]   = tag;
        bus.req_a[p]     = a;
        bus.req_b[p]     = b;
        bus.req_sqrt[p]  = sq;
        #1;
        chk("issue_grant", 64'(bus.req_ready), 64'(2'b01 << p));
        tick();
        bus.req_valid = '0;
        #1;
        chk("issue_div_in_valid", 64'(bus.div_in_valid), 64'd1);
        chk("issue_div_a", 64'(bus.div_a), 64'(a));
        chk("issue_div_b", 64'(bus.div_b), 64'(b));
        chk("issue_div_sqrt", 64'(bus.div_sqrt), 64'(sq));
        tick();
        chk("issue_in_wait", 64'(dut.st), 64'(WAIT));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // vld, sqn0, sqn1, brv, brs, expected req_ready (pointer at port 0)
        tbl[0]  = '{2'b00, 7'd0,   7'd0,   1'b0, 7'd0,   2'b00};
        tbl[1]  = '{2'b01, 7'd1,   7'd0,   1'b0, 7'd0,   2'b01};
        tbl[2]  = '{2'b10, 7'd0,   7'd1,   1'b0, 7'd0,   2'b10};
        tbl[3]  = '{2'b11, 7'd1,   7'd2,   1'b0, 7'd0,   2'b01};
        tbl[4]  = '{2'b01, 7'd2,   7'd0,   1'b1, 7'd120, 2'b00}; // 2-120 wraps to +10
        tbl[5]  = '{2'b01, 7'd3,   7'd0,   1'b1, 7'd3,   2'b01}; // equal: not killed
        tbl[6]  = '{2'b11, 7'd9,   7'd3,   1'b1, 7'd4,   2'b10}; // port0 +5 killed, port1 -1 kept
        tbl[7]  = '{2'b11, 7'd4,   7'd4,   1'b1, 7'd4,   2'b01};
        tbl[8]  = '{2'b01, 7'd0,   7'd0,   1'b1, 7'd64,  2'b01}; // diff -64: older
        tbl[9]  = '{2'b01, 7'd63,  7'd0,   1'b1, 7'd0,   2'b00}; // diff +63: younger
        tbl[10] = '{2'b11, 7'd10,  7'd127, 1'b1, 7'd126, 2'b00}; // +12 and +1: both killed
        tbl[11] = '{2'b01, 7'd100, 7'd0,   1'b0, 7'd0,   2'b01}; // no flush: nothing killed

        // Reset state, with both ports requesting during reset.
        drive_idle();
        bus.req_valid = 2'b11;
        tick();
        chk("rst_state", 64'(dut.st), 64'(IDLE));
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_div_in_valid", 64'(bus.div_in_valid), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        do_reset();

        // Grant/kill table in IDLE; valids are dropped before each edge so
        // nothing is accepted and the pointer stays at port 0.
        for (int i = 0; i < 12; i++) begin
            tick();
            bus.req_valid  = tbl[i].vld;
            bus.req_sqn[0] = tbl[i].sqn0;
            bus.req_sqn[1] = tbl[i].sqn1;
            bus.br_valid   = tbl[i].brv;
            bus.br_sqn     = tbl[i].brs;
            #1;
            chk($sformatf("tbl%0d_req_ready", i), 64'(bus.req_ready), 64'(tbl[i].exp_rdy));
            bus.req_valid = '0;
            bus.br_valid  = 1'b0;
        end

        // 4.0 / 2.0 on port 0, divider answers 10 cycles after acceptance.
        tick();
        issue(0, 7'd5, 7'h11, 32'h4080_0000, 32'h4000_0000, 1'b0);
        for (int c = 0; c < 9; c++) begin
            chk("div_busy_no_wb", 64'(bus.wb_valid), 64'd0);
            tick();
        end
        bus.div_out_valid  = 1'b1;
        bus.div_out_result = 32'h4000_0000;
        tick();
        bus.div_out_valid  = 1'b0;
        bus.div_out_result = 32'hDEAD_BEEF;
        chk("a_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("a_wb_tag", 64'(bus.wb_tag), 64'h11);
        chk("a_wb_sqn", 64'(bus.wb_sqn), 64'd5);
        chk("a_wb_result", 64'(bus.wb_result), 64'h4000_0000);
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        chk("a_back_idle", 64'(dut.st), 64'(IDLE));
        chk("a_wb_dropped", 64'(bus.wb_valid), 64'd0);

        // Round robin from a fresh pointer with both ports always valid.
        do_reset();
        bus.req_valid  = 2'b11;
        bus.req_tag[0] = 7'h10;
        bus.req_tag[1] = 7'h21;
        bus.req_sqn[0] = 7'd30;
        bus.req_sqn[1] = 7'd31;
        bus.wb_ack     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_grant", k), 64'(bus.req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            chk($sformatf("rr%0d_busy_ready", k), 64'(bus.req_ready), 64'd0);
            tick();
            bus.div_out_valid  = 1'b1;
            bus.div_out_result = 32'(k);
            tick();
            bus.div_out_valid = 1'b0;
            chk($sformatf("rr%0d_wb_tag", k), 64'(bus.wb_tag), (k % 2 == 0) ? 64'h10 : 64'h21);
            chk($sformatf("rr%0d_wb_result", k), 64'(bus.wb_result), 64'(k));
            tick();
        end
        bus.req_valid = '0;
        bus.wb_ack    = 1'b0;
        #1;

        // Flush while waiting: result must be drained and never written back.
        tick();
        issue(0, 7'd9, 7'h05, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        bus.br_valid = 1'b1;
        bus.br_sqn   = 7'd4;
        tick();
        bus.br_valid = 1'b0;
        chk("c_drain", 64'(dut.st), 64'(DRAIN));
        tick();
        tick();
        bus.div_out_valid  = 1'b1;
        bus.div_out_result = 32'h3F00_0000;
        #1;
        chk("c_drain_no_wb", 64'(bus.wb_valid), 64'd0);
        tick();
        bus.div_out_valid = 1'b0;
        chk("c_idle", 64'(dut.st), 64'(IDLE));
        chk("c_no_wb", 64'(bus.wb_valid), 64'd0);

        // Stray divider result in IDLE is ignored.
        bus.div_out_valid = 1'b1;
        tick();
        bus.div_out_valid = 1'b0;
        chk("stray_idle", 64'(dut.st), 64'(IDLE));
        chk("stray_no_wb", 64'(bus.wb_valid), 64'd0);

        // Flush in ISSUE while the divider is stalled.
        bus.req_valid  = 2'b01;
        bus.req_sqn[0] = 7'd20;
        #1;
        tick();
        bus.req_valid    = '0;
        bus.div_in_ready = 1'b0;
        #1;
        chk("iss_stall_valid", 64'(bus.div_in_valid), 64'd1);
        tick();
        bus.br_valid = 1'b1;
        bus.br_sqn   = 7'd10;
        #1;
        chk("iss_kill_no_req", 64'(bus.div_in_valid), 64'd0);
        tick();
        bus.br_valid     = 1'b0;
        bus.div_in_ready = 1'b1;
        chk("iss_kill_idle", 64'(dut.st), 64'(IDLE));

        // DONE held without ack, then kill and ack in the same cycle.
        issue(1, 7'd40, 7'h33, 32'h4100_0000, 32'h4080_0000, 1'b1);
        bus.div_out_valid  = 1'b1;
        bus.div_out_result = 32'h3F80_0000;
        tick();
        bus.div_out_valid = 1'b0;
        bus.req_valid     = 2'b01;
        for (int c = 0; c < 5; c++) begin
            chk("d_wb_valid", 64'(bus.wb_valid), 64'd1);
            chk("d_wb_tag", 64'(bus.wb_tag), 64'h33);
            chk("d_wb_sqn", 64'(bus.wb_sqn), 64'd40);
            chk("d_wb_result", 64'(bus.wb_result), 64'h3F80_0000);
            chk("d_req_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.req_valid = '0;
        bus.wb_ack    = 1'b1;
        bus.br_valid  = 1'b1;
        bus.br_sqn    = 7'd35;
        #1;
        chk("d_kill_beats_ack", 64'(bus.wb_valid), 64'd0);
        tick();
        bus.wb_ack   = 1'b0;
        bus.br_valid = 1'b0;
        chk("d_idle", 64'(dut.st), 64'(IDLE));

        // Reset in WAIT abandons the op.
        issue(0, 7'd50, 7'h07, 32'h4000_0000, 32'h4000_0000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("e_idle", 64'(dut.st), 64'(IDLE));
        chk("e_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("e_div_in_valid", 64'(bus.div_in_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
